// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the HI/LO register pair.
//   Runs MULT/MULTU/DIV/DIVU as a radix-2 shift-add / restoring shift-subtract
//   over WIDTH cycles, then one sign-fix cycle that writes HI/LO.
//   Also services MTHI/MTLO writes and the MFHI/MFLO read mux.
//
// Build option:
//   MDU_FAST_MUL_EN  - when defined, MULT/MULTU use a single-cycle WIDTH x WIDTH
//                      multiplier (busy for 1 cycle); DIV/DIVU stay iterative.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a mul/div op (ignored unless idle and aluop valid)
//   aluop  in   0000 MULT, 1000 MULTU, 0001 DIV, 1001 DIVU
//   a      in   multiplicand/dividend; MTHI/MTLO write data
//   b      in   multiplier/divisor
//   mthi   in   write a into HI (idle only)
//   mtlo   in   write a into LO (idle only)
//   mfhi   in   select HI onto rdata (priority over mflo)
//   mflo   in   select LO onto rdata
//   rdata  out  combinational HI/LO read data, 0 when neither selected
//   busy   out  registered, high while an op is in flight
//   done   out  registered one-cycle pulse when HI/LO take the result
//
// State table:
//   S_IDLE | waiting for start; MTHI/MTLO accepted
//   S_CALC | one radix-2 mul/div step per cycle, WIDTH cycles
//   S_FIX  | sign correction, HI/LO write, done pulse

module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_hi, r_lo;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier bits still to consume / dividend bits becoming quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // product/quotient sign
  logic               r_neg_r;     // remainder sign (dividend sign)
  logic               r_div0;
  logic               r_busy, r_done;

  logic               w_op_valid, w_go, w_is_div, w_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_last;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_shift, w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_op_valid = (aluop[2:1] == 2'b00);
  assign w_is_div   = aluop[0];
  assign w_signed   = ~aluop[3];
  assign w_go       = start && w_op_valid && (r_state == S_IDLE);

  assign w_a_neg = w_signed & a[WIDTH-1];
  assign w_b_neg = w_signed & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? (~a + 1'b1) : a;
  assign w_abs_b = w_b_neg ? (~b + 1'b1) : b;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: bring in the next dividend bit, subtract the divisor,
  // keep the difference only if it did not go negative.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_step  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  // Divide by zero yields an all-ones quotient; the remainder naturally
  // ends up as |a|, and its sign fix restores the original a.
  assign w_quo_fix  = r_div0  ? {WIDTH{1'b1}}
                    : (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                              : r_acc[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
`ifdef MDU_FAST_MUL_EN
          w_state_nxt = w_is_div ? S_CALC : S_FIX;
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_is_div && (b == '0);
            r_cnt    <= '0;
            r_opnd   <= w_abs_b;
`ifdef MDU_FAST_MUL_EN
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : w_fast_prod;
`else
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
`endif
          end else begin
            // Moves only land when no op is accepted this cycle.
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rdata = mfhi ? r_hi : (mflo ? r_lo : '0);
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b0001;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a, b;
  logic        mthi, mtlo, mfhi, mflo;
  logic [31:0] rdata;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Upstream must never move into HI/LO while the unit is busy.
  always @(posedge clk) begin
    if (busy === 1'b1 && (mthi === 1'b1 || mtlo === 1'b1)) begin
      bad++;
      $display("FAIL move_while_busy: mthi=%0b mtlo=%0b with busy=1", mthi, mtlo);
    end
  end

  // Reference: {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    case (op)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = ux * uy;
      OP_DIV: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          res = {32'(sr), 32'(sq)};
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          res = {32'(ur), 32'(uq)};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int busy_len(input logic [3:0] op);
`ifdef MDU_FAST_MUL_EN
    return op[0] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic with_mtlo);
    @(negedge clk);
    start = 1'b1; aluop = op; a = x; b = y; mtlo = with_mtlo;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Called at the negedge after the accepting edge; waits for done and checks all.
  task automatic finish_check(input logic [63:0] expv, input int exp_busy, input string nm);
    int nb;
    int guard;
    nb = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      if (busy === 1'b1) nb++;
      guard++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL %s_timeout: done=%b after %0d cycles, need 1", nm, done, guard);
    end
    total++;
    if (nb != exp_busy) begin
      bad++; $display("FAIL %s_busy_len: got %0d cycles, need %0d", nm, nb, exp_busy);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s_busy_at_done: got %b, need 0", nm, busy);
    end
    mfhi = 1'b1; #1;
    total++;
    if (rdata !== expv[63:32]) begin
      bad++; $display("FAIL %s_hi: got %h, need %h", nm, rdata, expv[63:32]);
    end
    mfhi = 1'b0; mflo = 1'b1; #1;
    total++;
    if (rdata !== expv[31:0]) begin
      bad++; $display("FAIL %s_lo: got %h, need %h", nm, rdata, expv[31:0]);
    end
    mflo = 1'b0;
    exp_hi = expv[63:32];
    exp_lo = expv[31:0];
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s_done_pulse: done=%b one cycle later, need 0", nm, done);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input string nm);
    logic [63:0] e;
    e = model(op, x, y);
    issue(op, x, y, 1'b0);
    finish_check(e, busy_len(op), nm);
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: busy=%b done=%b, need 0 0", busy, done);
    end
    mfhi = 1'b1; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h, need 0", rdata); end
    mfhi = 1'b0; mflo = 1'b1; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h, need 0", rdata); end
    mflo = 1'b0;
  endtask

  task automatic test_directed();
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    total++;
    if ({exp_hi, exp_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_max_model: got %h, need fffffffe00000001", {exp_hi, exp_lo});
    end
    do_op(OP_MULT,  32'hFFFF_FFF9, 32'd3,        "mult_neg");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        "div_neg");
    do_op(OP_DIVU,  32'd100,       32'd7,        "divu_100_7");
    do_op(OP_DIVU,  32'h0000_1234, 32'd0,        "divu_by0");
    do_op(OP_DIV,   32'hFFFF_FF00, 32'd0,        "div_neg_by0");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
    do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_pos_neg");
  endtask

  task automatic test_random();
    logic [3:0] ops [4];
    logic [3:0] op;
    logic [31:0] x, y;
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 3)];
      x = $urandom;
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) y = -y;
      do_op(op, x, y, "random");
    end
  endtask

  task automatic test_moves();
    @(negedge clk);
    mtlo = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    mtlo = 1'b0; mflo = 1'b1; #1;
    total++;
    if (rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mtlo_read: got %h, need a5a5a5a5", rdata); end
    mflo = 1'b0;
    mthi = 1'b1; mtlo = 1'b1; a = 32'h1357_9BDF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b1; mflo = 1'b1; #1;
    total++;
    if (rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL mthi_mtlo_both_hi: got %h, need 13579bdf", rdata); end
    mthi = 1'b1; a = 32'h0BAD_F00D;
    @(negedge clk);
    mthi = 1'b0; #1;
    total++;
    if (rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL mf_priority: got %h, need 0badf00d", rdata); end
    mfhi = 1'b0; #1;
    total++;
    if (rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL mthi_mtlo_both_lo: got %h, need 13579bdf", rdata); end
    mflo = 1'b0; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL rdata_none: got %h, need 0", rdata); end
    exp_hi = 32'h0BAD_F00D;
    exp_lo = 32'h1357_9BDF;
  endtask

  task automatic test_start_with_move();
    logic [63:0] e;
    logic [31:0] old_lo;
    old_lo = exp_lo;
    e = model(OP_DIVU, 32'hDEAD_0000, 32'd9);
    issue(OP_DIVU, 32'hDEAD_0000, 32'd9, 1'b1);
    mflo = 1'b1; #1;
    total++;
    if (rdata !== old_lo) begin bad++; $display("FAIL start_wins_move: got %h, need %h", rdata, old_lo); end
    mflo = 1'b0;
    finish_check(e, busy_len(OP_DIVU), "start_move");
  endtask

  task automatic test_start_while_busy();
    logic [63:0] e;
    logic [31:0] old_hi;
    old_hi = exp_hi;
    e = model(OP_DIVU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_op: cycle %0d got %b, need 1", i, busy); end
      if (i == 1) begin start = 1'b1; aluop = OP_MULTU; a = 32'd9; b = 32'd3; end
      if (i == 2) begin
        start = 1'b0;
        mfhi = 1'b1; #1;
        total++;
        if (rdata !== old_hi) begin bad++; $display("FAIL mfhi_while_busy: got %h, need %h", rdata, old_hi); end
        mfhi = 1'b0;
      end
      @(negedge clk);
    end
    finish_check(e, busy_len(OP_DIVU) - 5, "start_busy");
  endtask

  task automatic test_invalid_op();
    @(negedge clk);
    start = 1'b1; aluop = 4'b0010; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL invalid_op: busy=%b done=%b, need 0 0", busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    issue(OP_MULTU, 32'h7654_3210, 32'h0FED_CBA9, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_flags: busy=%b done=%b, need 0 0", busy, done);
    end
    mfhi = 1'b1; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL abort_hi: got %h, need 0", rdata); end
    mfhi = 1'b0; mflo = 1'b1; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL abort_lo: got %h, need 0", rdata); end
    mflo = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) begin
        total++; bad++;
        $display("FAIL abort_resume: busy=%b done=%b at cycle %0d, need 0 0", busy, done, i);
        break;
      end
    end
    exp_hi = '0; exp_lo = '0;
    do_op(OP_MULTU, 32'd3, 32'd5, "after_abort");
  endtask

  task automatic test_back_to_back();
    do_op(OP_MULT, 32'd12345, 32'hFFFF_FF85, "b2b_1");
    do_op(OP_DIV,  32'hFFFF_0000, 32'd17,    "b2b_2");
    do_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, "b2b_3");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; aluop = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_moves();
    test_start_with_move();
    test_start_while_busy();
    test_invalid_op();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
